boxcar_channel_scheduler: RTL and testbench

- Round-robin scheduler that time-multiplexes one shared boxcar_filter datapath between NCH sample requesters.
- Tags every issued sample with its channel, tracks it through the fixed-latency core, and returns the filtered result with its channel id.
- Provides a flush sequence that drains the core, then feeds zero samples per channel to clear filter history.

---
 rtl/boxcar_pkg.sv | 19 +
 rtl/boxcar_channel_scheduler_if.sv | 31 +++
 rtl/boxcar_channel_scheduler_rr_arbiter.sv | 35 +++
 rtl/boxcar_channel_scheduler.sv | 176 +++++++++++++++++
 tb/tb_boxcar_channel_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boxcar_pkg.sv
// rtl/boxcar_pkg.sv - shared types and helpers for the boxcar channel scheduler
package boxcar_pkg;

  // Scheduler states: grant (IDLE/RUN), wait for core to empty (DRAIN), zero-fill (FLUSH)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } sched_state_e;

  localparam int DEFAULT_DW = 8;

  // Channel-id width; never below one bit so a tag field always exists
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boxcar_channel_scheduler_if.sv
// rtl/boxcar_channel_scheduler_if.sv - requester, core and result signals of the scheduler
interface boxcar_channel_scheduler_if import boxcar_pkg::*; #(
  parameter int NCH = 4,
  parameter int DW  = DEFAULT_DW,
  localparam int CHW = chw(NCH)
);
  logic [NCH-1:0]    i_req;
  logic [NCH*DW-1:0] i_data;
  logic [NCH-1:0]    o_gnt;
  logic              i_flush;
  logic              o_busy;
  logic              o_core_valid;
  logic [DW-1:0]     o_core_data;
  logic [CHW-1:0]    o_core_chan;
  logic [DW-1:0]     i_core_data;
  logic              o_valid;
  logic [CHW-1:0]    o_chan;
  logic [DW-1:0]     o_data;

  // Scheduler side
  modport slave (
    input  i_req, i_data, i_flush, i_core_data,
    output o_gnt, o_busy, o_core_valid, o_core_data, o_core_chan, o_valid, o_chan, o_data
  );

  // Requesters plus core side
  modport master (
    output i_req, i_data, i_flush, i_core_data,
    input  o_gnt, o_busy, o_core_valid, o_core_data, o_core_chan, o_valid, o_chan, o_data
  );
endinterface

// File: rtl/boxcar_channel_scheduler_rr_arbiter.sv
// rtl/boxcar_channel_scheduler_rr_arbiter.sv - combinational round-robin grant from request and pointer
module rr_arbiter import boxcar_pkg::*; #(
  parameter int NCH = 4,
  localparam int CHW = chw(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CHW-1:0] ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [CHW-1:0] idx_o,
  output logic           any_o
);

  int             cand;
  logic [CHW-1:0] cidx;

  // Scan from the pointer upward with wrap; the first requester wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NCH) cand = cand - NCH;
      cidx = cand[CHW-1:0];
      if (!any_o && req_i[cidx]) begin
        any_o       = 1'b1;
        idx_o       = cidx;
        gnt_o[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/boxcar_channel_scheduler.sv
// rtl/boxcar_channel_scheduler.sv - round-robin sharing of one boxcar core among NCH channels
module boxcar_channel_scheduler import boxcar_pkg::*; #(
  parameter int NCH       = 4,
  parameter int DW        = DEFAULT_DW,
  parameter int CORE_LAT  = 2,
  parameter int FLUSH_LEN = 8,
  localparam int CHW = chw(NCH)
) (
  input  logic i_clk,
  input  logic i_reset,
  boxcar_channel_scheduler_if.slave bus
);

  localparam int NFL = NCH * FLUSH_LEN;
  localparam int CW  = $clog2(NFL + 1);

  sched_state_e   state_q, state_d;
  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  fcnt_q, fcnt_d;

  logic           core_valid_q, core_valid_d;
  logic [DW-1:0]  core_data_q, core_data_d;
  logic [CHW-1:0] core_chan_q, core_chan_d;
  logic           core_flush_q, core_flush_d;

  // Tag pipe: entry CORE_LAT-1 lines up with i_core_data
  logic [CORE_LAT-1:0] tv_q, tf_q;
  logic [CHW-1:0]      tc_q [CORE_LAT];

  logic           out_valid_q;
  logic [CHW-1:0] out_chan_q;
  logic [DW-1:0]  out_data_q;

  logic [NCH-1:0] arb_gnt;
  logic [CHW-1:0] arb_idx;
  logic           arb_any;
  logic           gnt_en;
  logic           pipe_busy;
  logic [DW-1:0]  sel_data;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req_i (bus.i_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign pipe_busy = |tv_q;

  // Sample of the arbitration winner
  always_comb begin
    sel_data = '0;
    for (int n = 0; n < NCH; n++) begin
      if (arb_idx == CHW'(n)) sel_data = bus.i_data[n*DW +: DW];
    end
  end

  // Next state, pointer, flush counter and core-stage inputs
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    fcnt_d       = fcnt_q;
    core_valid_d = 1'b0;
    core_data_d  = core_data_q;
    core_chan_d  = core_chan_q;
    core_flush_d = 1'b0;
    gnt_en       = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (bus.i_flush) begin
          state_d = ST_DRAIN;
        end else begin
          gnt_en = 1'b1;
          if (arb_any) begin
            core_valid_d = 1'b1;
            core_data_d  = sel_data;
            core_chan_d  = arb_idx;
            ptr_d        = (arb_idx == CHW'(NCH - 1)) ? '0 : arb_idx + CHW'(1);
          end
          state_d = (|bus.i_req) ? ST_RUN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!pipe_busy) begin
          state_d = ST_FLUSH;
          fcnt_d  = '0;
        end
      end
      ST_FLUSH: begin
        core_valid_d = 1'b1;
        core_data_d  = '0;
        core_chan_d  = CHW'(fcnt_q / CW'(FLUSH_LEN));
        core_flush_d = 1'b1;
        if (fcnt_q == CW'(NFL - 1)) begin
          state_d = ST_IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Registered sample and tag presented to the core
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      core_valid_q <= 1'b0;
      core_data_q  <= '0;
      core_chan_q  <= '0;
      core_flush_q <= 1'b0;
    end else begin
      core_valid_q <= core_valid_d;
      core_data_q  <= core_data_d;
      core_chan_q  <= core_chan_d;
      core_flush_q <= core_flush_d;
    end
  end

  // Tags ride alongside the core for CORE_LAT cycles
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tv_q <= '0;
      tf_q <= '0;
      for (int i = 0; i < CORE_LAT; i++) tc_q[i] <= '0;
    end else begin
      tv_q[0] <= core_valid_q;
      tf_q[0] <= core_flush_q;
      tc_q[0] <= core_chan_q;
      for (int i = 1; i < CORE_LAT; i++) begin
        tv_q[i] <= tv_q[i-1];
        tf_q[i] <= tf_q[i-1];
        tc_q[i] <= tc_q[i-1];
      end
    end
  end

  // Capture core output with its channel; flush results are dropped
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= tv_q[CORE_LAT-1] & ~tf_q[CORE_LAT-1];
      if (tv_q[CORE_LAT-1] && !tf_q[CORE_LAT-1]) begin
        out_chan_q <= tc_q[CORE_LAT-1];
        out_data_q <= bus.i_core_data;
      end
    end
  end

  assign bus.o_gnt        = arb_gnt & {NCH{gnt_en & ~i_reset}};
  assign bus.o_busy       = (state_q == ST_DRAIN) || (state_q == ST_FLUSH);
  assign bus.o_core_valid = core_valid_q;
  assign bus.o_core_data  = core_data_q;
  assign bus.o_core_chan  = core_chan_q;
  assign bus.o_valid      = out_valid_q;
  assign bus.o_chan       = out_chan_q;
  assign bus.o_data       = out_data_q;

endmodule

// File: tb/tb_boxcar_channel_scheduler.sv
// tb/tb_boxcar_channel_scheduler.sv - self-checking bench for boxcar_channel_scheduler
module tb_boxcar_channel_scheduler;
  import boxcar_pkg::*;

  localparam int NCH  = 4;
  localparam int DW   = 8;
  localparam int CL   = 2;
  localparam int FL   = 8;
  localparam int CHW  = chw(NCH);
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  boxcar_channel_scheduler_if #(.NCH(NCH), .DW(DW)) bus ();

  boxcar_channel_scheduler #(.NCH(NCH), .DW(DW), .CORE_LAT(CL), .FLUSH_LEN(FL)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Observed outputs per cycle
  logic [NCH-1:0] lg_gnt [MAXC];
  logic           lg_cv  [MAXC];
  logic [DW-1:0]  lg_cd  [MAXC];
  logic [CHW-1:0] lg_cc  [MAXC];
  logic           lg_ov  [MAXC];
  logic [CHW-1:0] lg_oc  [MAXC];
  logic [DW-1:0]  lg_od  [MAXC];
  logic           lg_busy[MAXC];
  logic [DW-1:0]  core_hist[MAXC];

  // Expected outputs per cycle, filled by the reference model
  bit [NCH-1:0] ex_gnt [MAXC];
  bit           ex_cv  [MAXC];
  bit [DW-1:0]  ex_cd  [MAXC];
  int           ex_cc  [MAXC];
  bit           ex_ov  [MAXC];
  int           ex_oc  [MAXC];
  int           ex_src [MAXC];
  bit           ex_busy[MAXC];

  // Reference model: 0 = accepting requests, 1 = waiting for core to empty, 2 = zero-filling
  int m_ptr = 0;
  int m_st = 0;
  int m_lastg = -100;
  int m_fl = 0;

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      lg_gnt[cyc]    = bus.o_gnt;
      lg_cv[cyc]     = bus.o_core_valid;
      lg_cd[cyc]     = bus.o_core_data;
      lg_cc[cyc]     = bus.o_core_chan;
      lg_ov[cyc]     = bus.o_valid;
      lg_oc[cyc]     = bus.o_chan;
      lg_od[cyc]     = bus.o_data;
      lg_busy[cyc]   = bus.o_busy;
      core_hist[cyc] = bus.i_core_data;
    end
  end

  // Drive one cycle of inputs and advance the reference model; g = modelled grant or -1
  task automatic tick(input logic [NCH-1:0] req, input logic [NCH*DW-1:0] data,
                      input bit flush, input bit r, output int g);
    int k;
    @(posedge clk);
    #1;
    cyc++;
    rst             = r;
    bus.i_req       = req;
    bus.i_data      = data;
    bus.i_flush     = flush;
    bus.i_core_data = DW'($urandom);
    g = -1;
    if (r) begin
      m_ptr = 0; m_st = 0; m_lastg = -100;
      for (int i = cyc; i < cyc + CL + 4; i++) begin
        ex_gnt[i] = '0; ex_cv[i] = 0; ex_ov[i] = 0; ex_busy[i] = 0;
      end
    end else if (m_st == 0) begin
      if (flush) begin
        m_st = 1;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          k = (m_ptr + i) % NCH;
          if (g < 0 && req[k]) g = k;
        end
      end
      if (g >= 0) begin
        ex_gnt[cyc]         = NCH'(1 << g);
        ex_cv[cyc+1]        = 1;
        ex_cc[cyc+1]        = g;
        ex_cd[cyc+1]        = data[g*DW +: DW];
        ex_ov[cyc+CL+2]     = 1;
        ex_oc[cyc+CL+2]     = g;
        ex_src[cyc+CL+2]    = cyc + CL + 1;
        m_ptr               = (g + 1) % NCH;
        m_lastg             = cyc;
      end
    end else if (m_st == 1) begin
      ex_busy[cyc] = 1;
      if (m_lastg + CL + 2 <= cyc) begin m_st = 2; m_fl = 0; end
    end else begin
      ex_busy[cyc]  = 1;
      ex_cv[cyc+1]  = 1;
      ex_cc[cyc+1]  = m_fl / FL;
      ex_cd[cyc+1]  = '0;
      m_fl++;
      if (m_fl == NCH * FL) m_st = 0;
    end
  endtask

  task automatic test_reset();
    int g;
    tick('1, {NCH*DW{1'b1}}, 0, 1, g);
    tick('1, {NCH*DW{1'b1}}, 0, 1, g);
    @(negedge clk);
    checks++; if (bus.o_gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b want=0", bus.o_gnt); end
    checks++; if (bus.o_core_valid !== 1'b0) begin failures++; $display("FAIL reset_core_valid got=%b want=0", bus.o_core_valid); end
    checks++; if (bus.o_core_data !== '0) begin failures++; $display("FAIL reset_core_data got=%h want=0", bus.o_core_data); end
    checks++; if (bus.o_core_chan !== '0) begin failures++; $display("FAIL reset_core_chan got=%0d want=0", bus.o_core_chan); end
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.o_valid); end
    checks++; if (bus.o_chan !== '0) begin failures++; $display("FAIL reset_chan got=%0d want=0", bus.o_chan); end
    checks++; if (bus.o_data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", bus.o_data); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.o_busy); end
    tick('0, '0, 0, 0, g);
  endtask

  task automatic test_single_requester();
    int g, c0, nres;
    logic [NCH*DW-1:0] d;
    d = {NCH*DW{1'b0}};
    d[1*DW +: DW] = 8'h40;
    c0 = cyc + 1;
    for (int i = 0; i < 3; i++) tick(4'b0010, d, 0, 0, g);
    for (int i = 0; i < 7; i++) tick('0, '0, 0, 0, g);
    @(negedge clk); #1;
    nres = 0;
    for (int c = c0; c <= cyc; c++) begin
      checks++; if (lg_gnt[c] !== ex_gnt[c]) begin failures++; $display("FAIL single_gnt cyc=%0d got=%b want=%b", c, lg_gnt[c], ex_gnt[c]); end
      checks++; if (lg_cv[c] !== ex_cv[c]) begin failures++; $display("FAIL single_core_valid cyc=%0d got=%b want=%b", c, lg_cv[c], ex_cv[c]); end
      if (ex_cv[c]) begin
        checks++; if (lg_cc[c] !== CHW'(ex_cc[c]) || lg_cd[c] !== ex_cd[c]) begin failures++; $display("FAIL single_core_sample cyc=%0d got=%0d/%h want=%0d/%h", c, lg_cc[c], lg_cd[c], ex_cc[c], ex_cd[c]); end
      end
      checks++; if (lg_ov[c] !== ex_ov[c]) begin failures++; $display("FAIL single_valid cyc=%0d got=%b want=%b", c, lg_ov[c], ex_ov[c]); end
      if (ex_ov[c]) begin
        checks++; if (lg_oc[c] !== CHW'(ex_oc[c]) || lg_od[c] !== core_hist[ex_src[c]]) begin failures++; $display("FAIL single_result cyc=%0d got=%0d/%h want=%0d/%h", c, lg_oc[c], lg_od[c], ex_oc[c], core_hist[ex_src[c]]); end
      end
      if (lg_ov[c] === 1'b1 && lg_oc[c] === CHW'(1)) nres++;
    end
    checks++; if (nres != 3) begin failures++; $display("FAIL single_result_count got=%0d want=3", nres); end
  endtask

  task automatic test_round_robin();
    int g, c0;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    logic [NCH*DW-1:0] d;
    tick('0, '0, 0, 1, g);
    tick('0, '0, 0, 0, g);
    d = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    c0 = cyc + 1;
    for (int i = 0; i < 6; i++) tick(4'b1111, d, 0, 0, g);
    for (int i = 0; i < 6; i++) tick('0, '0, 0, 0, g);
    @(negedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (lg_gnt[c0+i] !== NCH'(1 << order[i])) begin failures++; $display("FAIL rr_order step=%0d got=%b want=%b", i, lg_gnt[c0+i], NCH'(1 << order[i])); end
    end
    for (int c = c0; c <= cyc; c++) begin
      checks++; if (lg_cv[c] !== ex_cv[c]) begin failures++; $display("FAIL rr_core_valid cyc=%0d got=%b want=%b", c, lg_cv[c], ex_cv[c]); end
      if (ex_cv[c]) begin
        checks++; if (lg_cc[c] !== CHW'(ex_cc[c]) || lg_cd[c] !== ex_cd[c]) begin failures++; $display("FAIL rr_core_sample cyc=%0d got=%0d/%h want=%0d/%h", c, lg_cc[c], lg_cd[c], ex_cc[c], ex_cd[c]); end
      end
      checks++; if (lg_ov[c] !== ex_ov[c]) begin failures++; $display("FAIL rr_valid cyc=%0d got=%b want=%b", c, lg_ov[c], ex_ov[c]); end
      if (ex_ov[c]) begin
        checks++; if (lg_oc[c] !== CHW'(ex_oc[c]) || lg_od[c] !== core_hist[ex_src[c]]) begin failures++; $display("FAIL rr_result cyc=%0d got=%0d/%h want=%0d/%h", c, lg_oc[c], lg_od[c], ex_oc[c], core_hist[ex_src[c]]); end
      end
    end
  endtask

  task automatic test_pointer_wrap();
    int g, c0;
    int order[3] = '{3, 0, 3};
    tick('0, '0, 0, 1, g);
    tick('0, '0, 0, 0, g);
    tick(4'b0001, 32'h0000_0011, 0, 0, g);
    c0 = cyc + 1;
    for (int i = 0; i < 3; i++) tick(4'b1001, 32'h5500_0066, 0, 0, g);
    tick('0, '0, 0, 0, g);
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (lg_gnt[c0+i] !== NCH'(1 << order[i])) begin failures++; $display("FAIL ptr_wrap step=%0d got=%b want=%b", i, lg_gnt[c0+i], NCH'(1 << order[i])); end
    end
  endtask

  task automatic test_flush();
    int g, c0, f, nfl;
    tick('0, '0, 0, 0, g);
    c0 = cyc + 1;
    for (int i = 0; i < 3; i++) tick(4'b1111, {$urandom}, 0, 0, g);
    tick(4'b1111, {$urandom}, 1, 0, g);
    f = cyc;
    for (int i = 0; i < 45; i++) tick('0, '0, (i == 9), 0, g);
    @(negedge clk); #1;
    checks++; if (lg_gnt[f] !== '0) begin failures++; $display("FAIL flush_gnt_same_cycle got=%b want=0", lg_gnt[f]); end
    nfl = 0;
    for (int c = f + 1; c <= cyc; c++) begin
      if (lg_cv[c] === 1'b1) begin
        checks++; if (lg_cd[c] !== '0 || lg_cc[c] !== CHW'(nfl / FL)) begin failures++; $display("FAIL flush_sample idx=%0d got=%0d/%h want=%0d/00", nfl, lg_cc[c], lg_cd[c], nfl / FL); end
        nfl++;
      end
    end
    checks++; if (nfl != NCH * FL) begin failures++; $display("FAIL flush_count got=%0d want=%0d", nfl, NCH * FL); end
    for (int c = c0; c <= cyc; c++) begin
      checks++; if (lg_gnt[c] !== ex_gnt[c]) begin failures++; $display("FAIL flush_gnt cyc=%0d got=%b want=%b", c, lg_gnt[c], ex_gnt[c]); end
      checks++; if (lg_cv[c] !== ex_cv[c]) begin failures++; $display("FAIL flush_core_valid cyc=%0d got=%b want=%b", c, lg_cv[c], ex_cv[c]); end
      checks++; if (lg_ov[c] !== ex_ov[c]) begin failures++; $display("FAIL flush_valid cyc=%0d got=%b want=%b", c, lg_ov[c], ex_ov[c]); end
      if (ex_ov[c]) begin
        checks++; if (lg_oc[c] !== CHW'(ex_oc[c]) || lg_od[c] !== core_hist[ex_src[c]]) begin failures++; $display("FAIL flush_result cyc=%0d got=%0d/%h want=%0d/%h", c, lg_oc[c], lg_od[c], ex_oc[c], core_hist[ex_src[c]]); end
      end
      checks++; if (lg_busy[c] !== ex_busy[c]) begin failures++; $display("FAIL flush_busy cyc=%0d got=%b want=%b", c, lg_busy[c], ex_busy[c]); end
    end
  endtask

  task automatic test_reset_midflight();
    int g, c0, r0;
    c0 = cyc + 1;
    tick(4'b1111, {$urandom}, 0, 0, g);
    tick(4'b1111, {$urandom}, 0, 0, g);
    tick(4'b1111, {$urandom}, 0, 1, g);
    r0 = cyc;
    tick(4'b1111, {$urandom}, 0, 1, g);
    for (int i = 0; i < 8; i++) tick('0, '0, 0, 0, g);
    tick(4'b1111, {$urandom}, 0, 0, g);
    tick('0, '0, 0, 0, g);
    @(negedge clk); #1;
    checks++; if (lg_cd[r0] !== '0 || lg_cc[r0] !== '0 || lg_od[r0] !== '0 || lg_oc[r0] !== '0) begin failures++; $display("FAIL midreset_zero got=%h/%0d/%h/%0d want=0/0/0/0", lg_cd[r0], lg_cc[r0], lg_od[r0], lg_oc[r0]); end
    checks++; if (lg_gnt[cyc-1] !== 4'b0001) begin failures++; $display("FAIL midreset_ptr_restart got=%b want=0001", lg_gnt[cyc-1]); end
    for (int c = c0; c <= cyc; c++) begin
      checks++; if (lg_gnt[c] !== ex_gnt[c]) begin failures++; $display("FAIL midreset_gnt cyc=%0d got=%b want=%b", c, lg_gnt[c], ex_gnt[c]); end
      checks++; if (lg_cv[c] !== ex_cv[c]) begin failures++; $display("FAIL midreset_core_valid cyc=%0d got=%b want=%b", c, lg_cv[c], ex_cv[c]); end
      checks++; if (lg_ov[c] !== ex_ov[c]) begin failures++; $display("FAIL midreset_valid cyc=%0d got=%b want=%b", c, lg_ov[c], ex_ov[c]); end
      checks++; if (lg_busy[c] !== ex_busy[c]) begin failures++; $display("FAIL midreset_busy cyc=%0d got=%b want=%b", c, lg_busy[c], ex_busy[c]); end
    end
  endtask

  task automatic test_random();
    int g, c0;
    logic [NCH-1:0]    pend;
    logic [NCH*DW-1:0] pdat;
    bit fl;
    pend = '0;
    pdat = '0;
    c0 = cyc + 1;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < NCH; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          pdat[k*DW +: DW] = DW'($urandom);
        end
      end
      fl = ($urandom_range(0, 79) == 0);
      tick(pend, pdat, fl, 0, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    for (int i = 0; i < 45; i++) tick('0, '0, 0, 0, g);
    @(negedge clk); #1;
    for (int c = c0; c <= cyc; c++) begin
      checks++; if (lg_gnt[c] !== ex_gnt[c]) begin failures++; $display("FAIL rand_gnt cyc=%0d got=%b want=%b", c, lg_gnt[c], ex_gnt[c]); end
      checks++; if (lg_cv[c] !== ex_cv[c]) begin failures++; $display("FAIL rand_core_valid cyc=%0d got=%b want=%b", c, lg_cv[c], ex_cv[c]); end
      if (ex_cv[c]) begin
        checks++; if (lg_cc[c] !== CHW'(ex_cc[c]) || lg_cd[c] !== ex_cd[c]) begin failures++; $display("FAIL rand_core_sample cyc=%0d got=%0d/%h want=%0d/%h", c, lg_cc[c], lg_cd[c], ex_cc[c], ex_cd[c]); end
      end
      checks++; if (lg_ov[c] !== ex_ov[c]) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, lg_ov[c], ex_ov[c]); end
      if (ex_ov[c]) begin
        checks++; if (lg_oc[c] !== CHW'(ex_oc[c]) || lg_od[c] !== core_hist[ex_src[c]]) begin failures++; $display("FAIL rand_result cyc=%0d got=%0d/%h want=%0d/%h", c, lg_oc[c], lg_od[c], ex_oc[c], core_hist[ex_src[c]]); end
      end
      checks++; if (lg_busy[c] !== ex_busy[c]) begin failures++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", c, lg_busy[c], ex_busy[c]); end
    end
  endtask

  initial begin
    bus.i_req       = '0;
    bus.i_data      = '0;
    bus.i_flush     = 1'b0;
    bus.i_core_data = '0;
    test_reset();
    test_single_requester();
    test_round_robin();
    test_pointer_wrap();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
